// File: rtl/opcode_sequencer.sv
// opcode_sequencer: issues a buffered opcode program one word per cycle, once or looping
module opcode_sequencer #(
    parameter int DEPTH = 16,
    parameter int OPW   = 21
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       wr_en_in,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_in,
    input  logic [OPW-1:0]             wr_data_in,
    input  logic                       start_in,
    input  logic [$clog2(DEPTH):0]     len_in,
    input  logic                       loop_in,
    input  logic                       stop_in,
    output logic [OPW-1:0]             opcode_out,
    output logic                       en_out,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [$clog2(DEPTH)-1:0]   pc_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_n;
    logic [OPW-1:0] mem [DEPTH];
    logic [AW-1:0]  pc, pc_n;
    logic [LW-1:0]  len_q, len_n;
    logic           loop_q, loop_n;
    logic [OPW-1:0] op_n;
    logic           en_n, done_n, start_ok, last;

    always_ff @(posedge clk_in)
        if (state == IDLE && wr_en_in)
            mem[wr_addr_in] <= wr_data_in;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= IDLE;
            pc         <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            opcode_out <= '0;
            en_out     <= 1'b0;
            done_out   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            len_q      <= len_n;
            loop_q     <= loop_n;
            opcode_out <= op_n;
            en_out     <= en_n;
            done_out   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        len_n    = len_q;
        loop_n   = loop_q;
        op_n     = '0;
        en_n     = 1'b0;
        done_n   = 1'b0;
        start_ok = start_in && len_in != '0 && len_in <= LW'(DEPTH);
        last     = LW'(pc) + LW'(1) == len_q;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_n = RUN;
                    len_n   = len_in;
                    loop_n  = loop_in;
                    pc_n    = '0;
                    en_n    = 1'b1;
                    // a same-edge write to word 0 must be seen by the first issue
                    op_n    = (wr_en_in && wr_addr_in == '0) ? wr_data_in : mem[0];
                end
            end
            RUN: begin
                if (stop_in) begin
                    state_n = IDLE;
                    pc_n    = '0;
                end else if (last && !loop_q) begin
                    state_n = DONE;
                    pc_n    = '0;
                    done_n  = 1'b1;
                end else begin
                    pc_n = last ? '0 : pc + AW'(1);
                    en_n = 1'b1;
                    op_n = mem[pc_n];
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy_out = state == RUN;
    assign pc_out   = pc;
endmodule

// File: tb/tb_opcode_sequencer.sv
// tb_opcode_sequencer: directed and randomized checks against a program-buffer reference model
module tb_opcode_sequencer;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        wr_en_in;
    logic [3:0]  wr_addr_in;
    logic [20:0] wr_data_in;
    logic        start_in;
    logic [4:0]  len_in;
    logic        loop_in;
    logic        stop_in;
    logic [20:0] opcode_out;
    logic        en_out;
    logic        busy_out;
    logic        done_out;
    logic [3:0]  pc_out;

    logic [20:0] model [16];
    int tests = 0;
    int fails = 0;

    opcode_sequencer dut (
        .clk_in(clk_in), .rst_in(rst_in), .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in), .start_in(start_in), .len_in(len_in), .loop_in(loop_in),
        .stop_in(stop_in), .opcode_out(opcode_out), .en_out(en_out), .busy_out(busy_out),
        .done_out(done_out), .pc_out(pc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_en"}, 32'(en_out), 0);
        chk({tag, "_op"}, 32'(opcode_out), 0);
        chk({tag, "_busy"}, 32'(busy_out), 0);
        chk({tag, "_done"}, 32'(done_out), 0);
    endtask

    task automatic wr(input int a, input logic [20:0] d);
        wr_en_in = 1'b1;
        wr_addr_in = 4'(a);
        wr_data_in = d;
        step();
        wr_en_in = 1'b0;
        model[a] = d;
    endtask

    // Expected issue stream is simply model[i % len]; stop_at < 0 means no stop
    task automatic run(input int len, input bit lp, input int stop_at, input bit byp, input logic [20:0] bdata);
        int n;
        start_in = 1'b1;
        len_in = 5'(len);
        loop_in = lp;
        if (byp) begin
            wr_en_in = 1'b1;
            wr_addr_in = 4'd0;
            wr_data_in = bdata;
            model[0] = bdata;
        end
        step();
        start_in = 1'b0;
        wr_en_in = 1'b0;
        n = (stop_at >= 0 && (lp || stop_at < len)) ? stop_at + 1 : len;
        for (int i = 0; i < n; i++) begin
            chk("run_en", 32'(en_out), 1);
            chk("run_pc", 32'(pc_out), i % len);
            chk("run_op", 32'(opcode_out), 32'(model[i % len]));
            chk("run_busy", 32'(busy_out), 1);
            chk("run_done", 32'(done_out), 0);
            if (i == stop_at) begin
                stop_in = 1'b1;
                step();
                stop_in = 1'b0;
                idle_chk("stop");
                chk("stop_pc", 32'(pc_out), 0);
                step();
                idle_chk("after_stop");
                return;
            end
            step();
        end
        chk("fin_done", 32'(done_out), 1);
        chk("fin_en", 32'(en_out), 0);
        chk("fin_op", 32'(opcode_out), 0);
        chk("fin_busy", 32'(busy_out), 0);
        step();
        idle_chk("post_done");
    endtask

    initial begin
        int len, stop_at;
        bit lp;
        rst_in = 1'b0;
        wr_en_in = 1'b0;
        wr_addr_in = '0;
        wr_data_in = '0;
        start_in = 1'b0;
        len_in = '0;
        loop_in = 1'b0;
        stop_in = 1'b0;
        #3;
        idle_chk("reset");
        chk("reset_pc", 32'(pc_out), 0);
        step();
        step();
        rst_in = 1'b1;
        step();
        idle_chk("post_reset");

        for (int a = 0; a < 16; a++) wr(a, 21'($urandom));
        wr(0, 21'h00123);
        wr(1, 21'h00456);
        wr(2, 21'h1ABC7);
        run(3, 1'b0, -1, 1'b0, '0);
        run(3, 1'b1, 6, 1'b0, '0);

        stop_in = 1'b1;
        step();
        stop_in = 1'b0;
        idle_chk("idle_stop");
        start_in = 1'b1;
        len_in = 5'd0;
        step();
        idle_chk("len0");
        len_in = 5'd17;
        step();
        start_in = 1'b0;
        idle_chk("len17");

        for (int a = 0; a < 16; a++) wr(a, 21'($urandom));
        run(16, 1'b0, -1, 1'b0, '0);

        run(3, 1'b0, -1, 1'b1, 21'h0F0F0);

        // writes and starts while running must both be ignored
        start_in = 1'b1;
        len_in = 5'd2;
        loop_in = 1'b0;
        step();
        wr_en_in = 1'b1;
        wr_addr_in = 4'd1;
        wr_data_in = ~model[1];
        len_in = 5'd5;
        chk("wrrun_op0", 32'(opcode_out), 32'(model[0]));
        step();
        wr_en_in = 1'b0;
        start_in = 1'b0;
        chk("wrrun_pc1", 32'(pc_out), 1);
        chk("wrrun_op1", 32'(opcode_out), 32'(model[1]));
        step();
        chk("wrrun_done", 32'(done_out), 1);
        step();
        run(3, 1'b0, -1, 1'b0, '0);

        start_in = 1'b1;
        len_in = 5'd5;
        loop_in = 1'b0;
        step();
        start_in = 1'b0;
        step();
        chk("pre_rst_pc", 32'(pc_out), 1);
        #2 rst_in = 1'b0;
        #1;
        idle_chk("async_rst");
        chk("async_rst_pc", 32'(pc_out), 0);
        step();
        rst_in = 1'b1;
        step();
        idle_chk("rst_release");
        run(5, 1'b0, -1, 1'b0, '0);

        run(4, 1'b0, 3, 1'b0, '0);

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 3; k++) wr(int'($urandom_range(0, 15)), 21'($urandom));
            len = int'($urandom_range(1, 16));
            lp = 1'($urandom_range(0, 1));
            stop_at = lp ? int'($urandom_range(0, 40))
                         : ($urandom_range(0, 3) == 0 ? int'($urandom_range(0, len - 1)) : -1);
            run(len, lp, stop_at, 1'($urandom_range(0, 1)), 21'($urandom));
            start_in = 1'b1;
            len_in = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
            step();
            start_in = 1'b0;
            idle_chk("bad_len");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/opcode_sequencer.md
OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 Parameter DEPTH, default 16: number of program-buffer entries.
REQ-002 Parameter OPW, default 21: opcode word width, in the accumulator-ALU control word format.
REQ-003 clk_in  input  1: single clock; all state is updated on its rising edge.
REQ-004 rst_in  input  1: reset, asynchronous and active-low.
REQ-005 wr_en_in  input  1: program-buffer write strobe.
REQ-006 wr_addr_in  input  4: program-buffer write address.
REQ-007 wr_data_in  input  OPW: opcode word to write.
REQ-008 start_in  input  1: begin issuing the program.
REQ-009 len_in  input  5: program length, valid values 1..16, sampled on start.
REQ-010 loop_in  input  1: repeat the program indefinitely, sampled on start.
REQ-011 stop_in  input  1: abort issue.
REQ-012 opcode_out  output  OPW: issued opcode word, registered.
REQ-013 en_out  output  1: opcode_out is valid; drives the consumer's enable.
REQ-014 busy_out  output  1: high while in RUN.
REQ-015 done_out  output  1: one-cycle pulse when a non-looping program completes.
REQ-016 pc_out  output  4: index of the word currently on opcode_out.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 Buffer writes SHALL occur only in IDLE (mem[wr_addr_in] <= wr_data_in); writes in RUN or DONE are ignored.
REQ-019 In IDLE, start_in=1 with len_in in 1..16 SHALL:
- latch len_in and loop_in;
- go to RUN;
- on the same edge, register opcode_out=mem[0], en_out=1, pc_out=0.
REQ-020 In IDLE, start_in=1 with len_in=0 or len_in>16 SHALL be ignored (remain in IDLE).
REQ-021 A write to address 0 on the same edge as an accepted start SHALL be bypassed, so opcode_out carries the new wr_data_in.
REQ-022 In RUN, each edge SHALL advance by one word: pc_out increments and opcode_out=mem[pc]; one word is issued per cycle with no bubbles.
REQ-023 In RUN, on the edge after word len-1 is issued:
- loop=1: pc=0, opcode_out=mem[0], remain in RUN;
- loop=0: go to DONE with en_out=0, opcode_out=0, done_out=1.
REQ-024 DONE SHALL last exactly one cycle, then return to IDLE with done_out=0.
REQ-025 stop_in=1 in RUN SHALL, on the next edge, force IDLE with en_out=0, opcode_out=0, pc_out=0 and no done_out pulse; stop wins over completion on the same edge.
REQ-026 start_in in RUN or DONE SHALL be ignored; stop_in in IDLE or DONE SHALL be ignored.
REQ-027 In IDLE and DONE, en_out=0 and opcode_out=0.
REQ-028 busy_out SHALL be 1 only in RUN.
REQ-029 The pc SHALL wrap from len-1 to 0 only when looping; it never exceeds len-1.

Reset
REQ-030 rst_in=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- opcode_out=0, en_out=0, busy_out=0, done_out=0, pc_out=0;
- latched len=0 and loop=0.
REQ-031 Program-buffer contents SHALL NOT be cleared by reset.
REQ-032 Reset asserted mid-RUN SHALL abort issue with no done_out pulse; after release, a new start is required.

Verification
REQ-033 Load mem[0..2]=0x00123, 0x00456, 0x1ABC7; start with len=3, loop=0 -> en_out=1 for 3 cycles issuing those words in order (pc 0,1,2); then en_out=0 with done_out=1 for one cycle; busy_out=0 after.
REQ-034 Same program with loop=1, held for 7 cycles -> issue sequence 0,1,2,0,1,2,0; no done_out; stop_in on cycle 7 -> en_out=0 next edge, no done_out.
REQ-035 start with len=0 -> no state change; start with len=16 over a full buffer -> 16 consecutive words issued, pc ends at 15, then done_out pulse.
REQ-036 Write addr 0 = 0x0F0F0 on the same edge as start -> first opcode_out=0x0F0F0; a write attempted during RUN -> buffer unchanged, verified by re-running.
REQ-037 rst_in=0 asynchronously mid-RUN (between edges) -> outputs 0 immediately; after release, buffer contents are unchanged and the program reruns correctly.
REQ-038 stop_in asserted on the cycle the last word is issued (loop=0) -> next edge IDLE, done_out stays 0.
